// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, sentinel addresses and colour types for
// the VGA scan compositor and its timing generator.
//   H_*_DEF / V_*_DEF : 640x480@60 defaults (25 MHz pixel clock)
//   H_TOTAL / V_TOTAL : line and frame lengths for the defaults
//   ROW_NONE/COL_NONE : addresses driven during blanking, outside any sprite
//   rgb12_t           : 4:4:4 colour word {r,g,b}
//   pick_layer()      : priority resolve, lowest set layer index wins
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int N_LAYERS = 4;

  localparam logic [8:0] ROW_NONE = 9'h1FF;
  localparam logic [9:0] COL_NONE = 10'h3FF;

  typedef logic [11:0] rgb12_t;

  // Written as a concatenation, so the rightmost entry is layer 0:
  // layer0=999, layer1=777, layer2=555, layer3=333.
  localparam logic [N_LAYERS*12-1:0] LAYER_COLORS_DEF =
    {12'h333, 12'h555, 12'h777, 12'h999};
  localparam rgb12_t BG_COLOR_DEF = 12'hFFF;
  localparam rgb12_t BORDER_COLOR = 12'hF00;

  // Walk from the highest index down so the lowest set layer is the last
  // (and therefore winning) assignment.
  function automatic rgb12_t pick_layer(input logic [N_LAYERS-1:0] px,
                                        input logic [N_LAYERS*12-1:0] colors,
                                        input rgb12_t bg);
    rgb12_t c;
    c = bg;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (px[i]) c = colors[i*12 +: 12];
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_compositor_if.sv
// vga_scan_compositor_if: bundle between the compositor, the sprite
// renderers and the VGA pins.
//   px        : sprite pixel replies, bit i = layer i (one cycle behind addr)
//   row_addr  : current row, ROW_NONE in vertical blanking
//   col_addr  : current column, COL_NONE in horizontal blanking
//   fresh     : high while scanning active rows
//   hs, vs    : active-low syncs, aligned with r/g/b
//   r, g, b   : 4-bit colour channels
//   frame_cnt : completed-frame counter
// master = compositor side, slave = sprites/pins side.
interface vga_scan_compositor_if;
  import vga_pkg::*;

  logic [N_LAYERS-1:0] px;
  logic [8:0]          row_addr;
  logic [9:0]          col_addr;
  logic                fresh;
  logic                hs;
  logic                vs;
  logic [3:0]          r;
  logic [3:0]          g;
  logic [3:0]          b;
  logic [15:0]         frame_cnt;

  modport master (
    input  px,
    output row_addr, col_addr, fresh, hs, vs, r, g, b, frame_cnt
  );

  modport slave (
    output px,
    input  row_addr, col_addr, fresh, hs, vs, r, g, b, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters and raw (undelayed) timing flags.
//   clk, RESET_N : pixel clock, async active-low reset
//   h_cnt        : column counter 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1
//   v_row        : low 9 bits of the line counter
//   h_active     : h_cnt in the visible columns
//   v_active     : line counter in the visible rows
//   hsync_n      : low inside the horizontal sync window
//   vsync_n      : low inside the vertical sync window
//   frame_cnt    : increments as the line counter wraps, 16-bit wrap
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        RESET_N,
  output logic [9:0]  h_cnt,
  output logic [8:0]  v_row,
  output logic        h_active,
  output logic        v_active,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic [15:0] frame_cnt
);

  localparam int H_PERIOD = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_PERIOD = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_PERIOD - 1);
  localparam logic [9:0] V_LAST   = 10'(V_PERIOD - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] v_cnt;

  // h and v wrap on the same edge at the last pixel of the frame, and the
  // frame counter steps on that same edge.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign v_row    = v_cnt[8:0];
  assign h_active = (h_cnt < H_VIS);
  assign v_active = (v_cnt < V_VIS);
  assign hsync_n  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync_n  = !((v_cnt >= VS_START) && (v_cnt < VS_END));

endmodule

// File: rtl/vga_scan_compositor.sv
// vga_scan_compositor: 640x480@60 raster scan, sprite addressing and
// priority compositing into 12-bit RGB with aligned syncs.
//   clk     : pixel clock (25 MHz)
//   RESET_N : async active-low reset
//   bus     : vga_scan_compositor_if.master (px in; addresses, fresh,
//             hs/vs, r/g/b, frame_cnt out)
// Pipeline: counters (t) -> addresses/flags (t+1) -> flags aligned with the
// sprites' registered px (t+2) -> pins (t+3).
// Optional build macro VGA_DEBUG_BORDER_EN: paints the outermost active
// rows/columns 12'hF00 over all layers, same latency.
module vga_scan_compositor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter logic [N_LAYERS*12-1:0] LAYER_COLORS = LAYER_COLORS_DEF,
  parameter rgb12_t BG_COLOR = BG_COLOR_DEF
) (
  input logic                   clk,
  input logic                   RESET_N,
  vga_scan_compositor_if.master bus
);

  logic [9:0]  h_cnt;
  logic [8:0]  v_row;
  logic        h_active;
  logic        v_active;
  logic        hsync_n;
  logic        vsync_n;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .RESET_N   (RESET_N),
    .h_cnt     (h_cnt),
    .v_row     (v_row),
    .h_active  (h_active),
    .v_active  (v_active),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .frame_cnt (frame_cnt)
  );

  logic [9:0] col_q;
  logic [8:0] row_q;
  logic       fresh_q;
  logic       act1, act2;
  logic       hs1, hs2, hs_q;
  logic       vs1, vs2, vs_q;
  rgb12_t     rgb_q;

`ifdef VGA_DEBUG_BORDER_EN
  localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] ROW_LAST = 9'(V_ACTIVE - 1);
  logic brd1, brd2;
`endif

  // Syncs reset high so the pins sit idle (not in sync) through reset.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      col_q   <= '0;
      row_q   <= '0;
      fresh_q <= 1'b1;
      act1    <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      act2    <= 1'b0;
      hs2     <= 1'b1;
      vs2     <= 1'b1;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
`ifdef VGA_DEBUG_BORDER_EN
      brd1    <= 1'b0;
      brd2    <= 1'b0;
`endif
    end else begin
      col_q   <= h_active ? h_cnt : COL_NONE;
      row_q   <= v_active ? v_row : ROW_NONE;
      fresh_q <= v_active;
      act1    <= h_active && v_active;
      hs1     <= hsync_n;
      vs1     <= vsync_n;

      act2    <= act1;
      hs2     <= hs1;
      vs2     <= vs1;

      // px arrives here directly from the sprites, already one cycle behind
      // the addresses, so it lines up with the stage-2 flags.
      hs_q    <= hs2;
      vs_q    <= vs2;
      if (!act2) begin
        rgb_q <= '0;
      end
`ifdef VGA_DEBUG_BORDER_EN
      else if (brd2) begin
        rgb_q <= BORDER_COLOR;
      end
`endif
      else begin
        rgb_q <= pick_layer(bus.px, LAYER_COLORS, BG_COLOR);
      end

`ifdef VGA_DEBUG_BORDER_EN
      // Only meaningful when act1 is set; the row compare relies on that.
      brd1 <= (h_cnt == 10'd0) || (h_cnt == COL_LAST) ||
              (v_row == 9'd0)  || (v_row == ROW_LAST);
      brd2 <= brd1;
`endif
    end
  end

  assign bus.col_addr  = col_q;
  assign bus.row_addr  = row_q;
  assign bus.fresh     = fresh_q;
  assign bus.hs        = hs_q;
  assign bus.vs        = vs_q;
  assign bus.r         = rgb_q[11:8];
  assign bus.g         = rgb_q[7:4];
  assign bus.b         = rgb_q[3:0];
  assign bus.frame_cnt = frame_cnt;

endmodule
